// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants, colour constants and types for the display path.
package vga_timing_pkg;

   // Coordinate width shared with the pixel renderers
   localparam int unsigned COORD_W = 10;
   localparam int unsigned RGB_W   = 12;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [RGB_W-1:0]   rgb_t;

   // 640x480 @ 60 Hz timing
   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_FRONT   = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BACK    = 48;
   localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int unsigned V_VISIBLE = 480;
   localparam int unsigned V_FRONT   = 10;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BACK    = 33;
   localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // RGB444 colours
   localparam rgb_t FG_COLOR = 12'h000;
   localparam rgb_t BG_COLOR = 12'hFFF;
   localparam rgb_t BLACK    = 12'h000;

   // Raw sync/blank decode travelling down the alignment pipeline
   typedef struct packed {
      logic hs;
      logic vs;
      logic vis;
   } sync_t;

   // Idle value: both syncs deasserted (high), not visible
   localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a programmable async-reset value.
module vga_delay_line #(
   parameter int unsigned      WIDTH   = 1,
   parameter int unsigned      DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [DEPTH-1:0][WIDTH-1:0] sr_q;

   generate
      if (DEPTH == 1) begin : g_single
         // Single stage: plain register
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sr_q <= RST_VAL;
            end else begin
               sr_q <= d_i;
            end
         end
      end else begin : g_multi
         // Multi stage: shift toward the top index, oldest sample at DEPTH-1
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sr_q <= {DEPTH{RST_VAL}};
            end else begin
               sr_q <= {sr_q[DEPTH-2:0], d_i};
            end
         end
      end
   endgenerate

   assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// VGA raster generator: scan counters, sync/blank decode aligned to renderer latency,
// pixel-to-colour mapping and a frame-start tick.
module vga_timing #(
   parameter int unsigned H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
   parameter int unsigned H_FRONT     = vga_timing_pkg::H_FRONT,
   parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BACK      = vga_timing_pkg::H_BACK,
   parameter int unsigned V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
   parameter int unsigned V_FRONT     = vga_timing_pkg::V_FRONT,
   parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BACK      = vga_timing_pkg::V_BACK,
   parameter int unsigned PIX_LATENCY = 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                pixel_in,
   output logic [vga_timing_pkg::COORD_W-1:0]  haddress,
   output logic [vga_timing_pkg::COORD_W-1:0]  vaddress,
   output logic                                hsync,
   output logic                                vsync,
   output logic                                video_on,
   output logic [vga_timing_pkg::RGB_W-1:0]    rgb,
   output logic                                frame_tick
);

   import vga_timing_pkg::*;

   // Counter limits and decode windows in coordinate width
   localparam coord_t H_LAST     = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam coord_t V_LAST     = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
   localparam coord_t H_SYNC_LO  = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t H_SYNC_HI  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam coord_t V_SYNC_LO  = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t V_SYNC_HI  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   coord_t h_q, h_d;
   coord_t v_q, v_d;
   logic   frame_tick_q;
   sync_t  sync_c;
   sync_t  sync_dly;
   logic   hsync_q;
   logic   vsync_q;
   logic   video_on_q;
   rgb_t   rgb_q;

   // Next scan position: advance pixel, wrap line, wrap frame on the same clock
   always_comb begin
      h_d = h_q + coord_t'(1);
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         if (v_q == V_LAST) begin
            v_d = '0;
         end else begin
            v_d = v_q + coord_t'(1);
         end
      end
   end

   // Scan counters and the undelayed frame-start tick
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_q          <= '0;
         v_q          <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         h_q          <= h_d;
         v_q          <= v_d;
         frame_tick_q <= (h_d == '0) && (v_d == '0);
      end
   end

   // Raw sync and visibility decode of the current scan position
   always_comb begin
      sync_c     = SYNC_IDLE;
      sync_c.vis = (h_q < H_VIS_END) && (v_q < V_VIS_END);
      sync_c.hs  = !((h_q >= H_SYNC_LO) && (h_q <= H_SYNC_HI));
      sync_c.vs  = !((v_q >= V_SYNC_LO) && (v_q <= V_SYNC_HI));
   end

   // Hold the decode back until the renderers' pixel for this position arrives
   vga_delay_line #(
      .WIDTH   ($bits(sync_t)),
      .DEPTH   (PIX_LATENCY),
      .RST_VAL (SYNC_IDLE)
   ) u_sync_dly (
      .clk   (clk),
      .rst_n (reset),
      .d_i   (sync_c),
      .q_o   (sync_dly)
   );

   // Output stage: register syncs, blanking and the colour-mapped pixel together
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         video_on_q <= 1'b0;
         rgb_q      <= BLACK;
      end else begin
         hsync_q    <= sync_dly.hs;
         vsync_q    <= sync_dly.vs;
         video_on_q <= sync_dly.vis;
         rgb_q      <= sync_dly.vis ? (pixel_in ? FG_COLOR : BG_COLOR) : BLACK;
      end
   end

   assign haddress   = h_q;
   assign vaddress   = v_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign video_on   = video_on_q;
   assign rgb        = rgb_q;
   assign frame_tick = frame_tick_q;

endmodule
